// File: rtl/uvmt_mem_st_rst_seq_pkg.sv
// Shared types and default constants for the memory self-test reset sequencer.
// The optional watchdog is enabled with the UVMT_MEM_ST_RST_SEQ_WDOG_EN macro.
package uvmt_mem_st_rst_seq_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_POR_CYCLES  = 16;
    localparam int DEF_WDOG_CYCLES = 1024;

    // Sequencer states: IDLE waits for work, ASSERT drives reset, SETTLE
    // releases reset for a quiet period, DONE pulses completion.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } uvmt_mem_st_rst_seq_state_t;

    // Pointer width for a requester count, never below one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uvmt_mem_st_rr_arb.sv
// Combinational round-robin arbiter: scans req starting at ptr and grants
// the first requester found. The pointer register is kept by the parent.
module uvmt_mem_st_rr_arb
    import uvmt_mem_st_rst_seq_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requesters in rotated order; the first one set wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uvmt_mem_st_rst_seq.sv
// Bench-wide reset sequencer. Runs a power-on sequence after reset_n release,
// then serves reset requests round-robin. Each sequence is an assert phase,
// a settle phase and a one-cycle done pulse.
// Handshake: req is a level; a requester owns the sequence while its grant
// bit is high (ASSERT through DONE). Dropping req mid-sequence does not abort;
// a req still high once back in IDLE is arbitrated again.
// Optional watchdog: define UVMT_MEM_ST_RST_SEQ_WDOG_EN.
module uvmt_mem_st_rst_seq
    import uvmt_mem_st_rst_seq_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int POR_CYCLES  = DEF_POR_CYCLES,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [CNT_W-1:0]           hold_cycles,
    input  logic [CNT_W-1:0]           settle_cycles,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       rst_out,
    output logic                       rst_out_n,
    output logic                       busy,
    output logic                       done,
    output uvmt_mem_st_rst_seq_state_t state_dbg
`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
    ,
    input  logic                       wdog_kick,
    output logic                       wdog_fired
`endif
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    uvmt_mem_st_rst_seq_state_t state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   settle_lat;
    logic [CNT_W-1:0]   settle_eff;
    logic [CNT_W-1:0]   hold_m1;
    logic               por_first;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               wdog_hit;

    uvmt_mem_st_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // Encode the one-hot winner so the pointer can advance past it.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) win_idx = PTR_W'(i);
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    // A hold of zero still asserts reset for one cycle.
    assign hold_m1 = (hold_cycles == '0) ? '0 : hold_cycles - CNT_W'(1);

    // The POR sequence has no grant edge to latch settle on, so its first
    // post-release cycle reads settle_cycles directly.
    assign settle_eff = por_first ? settle_cycles : settle_lat;

    assign rst_out_n = ~rst_out;
    assign state_dbg = state;

`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_hit = (state == ST_IDLE) && !wdog_kick &&
                      (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    // Count unkicked idle cycles; fire on the cycle that reaches the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt   <= '0;
            wdog_fired <= 1'b0;
        end else begin
            wdog_fired <= wdog_hit;
            if ((state != ST_IDLE) || wdog_kick || wdog_hit) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Sequencer FSM with all outputs registered from the next-state decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ASSERT;
            cnt        <= CNT_W'(POR_CYCLES - 1);
            settle_lat <= '0;
            por_first  <= 1'b1;
            ptr        <= '0;
            grant      <= '0;
            rst_out    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done      <= 1'b0;
            por_first <= 1'b0;
            if (por_first) settle_lat <= settle_cycles;

            case (state)
                ST_IDLE: begin
                    if (wdog_hit) begin
                        state      <= ST_ASSERT;
                        cnt        <= CNT_W'(POR_CYCLES - 1);
                        settle_lat <= settle_cycles;
                        rst_out    <= 1'b1;
                        busy       <= 1'b1;
                    end else if (|req) begin
                        state      <= ST_ASSERT;
                        cnt        <= hold_m1;
                        settle_lat <= settle_cycles;
                        grant      <= arb_gnt;
                        ptr        <= ptr_nxt;
                        rst_out    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ST_ASSERT: begin
                    if (cnt == '0) begin
                        rst_out <= 1'b0;
                        if (settle_eff != '0) begin
                            state <= ST_SETTLE;
                            cnt   <= settle_eff - CNT_W'(1);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uvmt_mem_st_rst_seq.sv
// Directed bench for the reset sequencer. Outputs are sampled on the falling
// clock edge; inputs change on the falling edge or just after a rising edge.
module tb_uvmt_mem_st_rst_seq;
    import uvmt_mem_st_rst_seq_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;
    localparam int POR     = 16;
    localparam int WDOG    = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [CNT_W-1:0]   hold_cycles = '0;
    logic [CNT_W-1:0]   settle_cycles = 16'd4;
    logic [NUM_REQ-1:0] grant;
    logic               rst_out;
    logic               rst_out_n;
    logic               busy;
    logic               done;
    uvmt_mem_st_rst_seq_state_t state_dbg;
`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
    logic               wdog_kick = 1'b0;
    logic               wdog_fired;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Results of the last observed sequence.
    int                 m_busy, m_hi, m_settle, m_done, m_done_pos, m_bad_n;
    logic [NUM_REQ-1:0] m_first_gnt;
    logic               m_gnt_stable;
    logic               m_first_fired;

    uvmt_mem_st_rst_seq #(
        .NUM_REQ     (NUM_REQ),
        .CNT_W       (CNT_W),
        .POR_CYCLES  (POR),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .hold_cycles   (hold_cycles),
        .settle_cycles (settle_cycles),
        .grant         (grant),
        .rst_out       (rst_out),
        .rst_out_n     (rst_out_n),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg)
`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
        ,
        .wdog_kick     (wdog_kick),
        .wdog_fired    (wdog_fired)
`endif
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Observe one sequence: sample each falling edge while busy (bounded).
    // Returns with the first idle sample taken.
    task automatic measure(input logic keep_req);
        m_busy = 0; m_hi = 0; m_settle = 0; m_done = 0; m_done_pos = 0; m_bad_n = 0;
        m_gnt_stable = 1'b1;
        m_first_fired = 1'b0;
        @(negedge clk);
        m_first_gnt = grant;
`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
        m_first_fired = wdog_fired;
`endif
        if (!keep_req) req = '0;
        while (busy && m_busy < 200) begin
            m_busy++;
            if (rst_out) m_hi++;
            if (done) begin
                m_done++;
                m_done_pos = m_busy;
            end else if (!rst_out) begin
                m_settle++;
            end
            if (grant !== m_first_gnt) m_gnt_stable = 1'b0;
            if (rst_out_n !== ~rst_out) m_bad_n++;
            @(negedge clk);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (rst_out !== 1'b1 || rst_out_n !== 1'b0 || busy !== 1'b1 ||
            grant !== 2'b00 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: rst_out=%b rst_out_n=%b busy=%b grant=%b done=%b required 1 0 1 00 0",
                     rst_out, rst_out_n, busy, grant, done);
        end
    endtask

    task automatic check_por(input string name);
        tests_run++;
        if (m_hi !== POR || m_settle !== 4 || m_done !== 1 || m_busy !== POR + 5) begin
            tests_failed++;
            $display("FAIL %s_timing: hi=%0d settle=%0d done=%0d busy=%0d required %0d 4 1 %0d",
                     name, m_hi, m_settle, m_done, m_busy, POR, POR + 5);
        end
        tests_run++;
        if (m_first_gnt !== 2'b00 || m_gnt_stable !== 1'b1 || m_bad_n !== 0) begin
            tests_failed++;
            $display("FAIL %s_grant: first_grant=%b stable=%b rst_n_errs=%0d required 00 1 0",
                     name, m_first_gnt, m_gnt_stable, m_bad_n);
        end
    endtask

    task automatic test_por();
        settle_cycles = 16'd4;
        release_reset();
        measure(1'b0);
        check_por("por");
    endtask

    task automatic test_single();
        req = 2'b01; hold_cycles = 16'd3; settle_cycles = 16'd0;
        measure(1'b0);
        tests_run++;
        if (m_first_gnt !== 2'b01 || m_gnt_stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: grant=%b stable=%b required 01 1", m_first_gnt, m_gnt_stable);
        end
        tests_run++;
        if (m_hi !== 3 || m_settle !== 0 || m_busy !== 4 || m_done !== 1 || m_done_pos !== 4) begin
            tests_failed++;
            $display("FAIL single_timing: hi=%0d settle=%0d busy=%0d done=%0d at %0d required 3 0 4 1 at 4",
                     m_hi, m_settle, m_busy, m_done, m_done_pos);
        end
        tests_run++;
        if (grant !== 2'b00 || busy !== 1'b0 || rst_out_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_idle: grant=%b busy=%b rst_out_n=%b required 00 0 1", grant, busy, rst_out_n);
        end
    endtask

    // Hold of zero, with req dropped while the sequence is in ASSERT.
    task automatic test_hold_zero();
        req = 2'b10; hold_cycles = 16'd0; settle_cycles = 16'd2;
        measure(1'b0);
        tests_run++;
        if (m_first_gnt !== 2'b10 || m_gnt_stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold0_grant: grant=%b stable=%b required 10 1", m_first_gnt, m_gnt_stable);
        end
        tests_run++;
        if (m_hi !== 1 || m_settle !== 2 || m_busy !== 4 || m_done !== 1 || m_done_pos !== 4) begin
            tests_failed++;
            $display("FAIL hold0_timing: hi=%0d settle=%0d busy=%0d done=%0d at %0d required 1 2 4 1 at 4",
                     m_hi, m_settle, m_busy, m_done, m_done_pos);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_g;
        req = 2'b11; hold_cycles = 16'd1; settle_cycles = 16'd1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            measure(1'b1);
            tests_run++;
            if (m_first_gnt !== exp_g || m_hi !== 1 || m_settle !== 1 || m_busy !== 3 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_seq%0d: grant=%b hi=%0d settle=%0d busy_len=%0d idle_busy=%b required %b 1 1 3 0",
                         k, m_first_gnt, m_hi, m_settle, m_busy, busy, exp_g);
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        req = 2'b01; hold_cycles = 16'd2; settle_cycles = 16'd5;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (rst_out !== 1'b0 || busy !== 1'b1 || grant !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_in_settle: rst_out=%b busy=%b grant=%b required 0 1 01", rst_out, busy, grant);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (rst_out !== 1'b1 || rst_out_n !== 1'b0 || grant !== 2'b00 || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: rst_out=%b rst_out_n=%b grant=%b busy=%b done=%b required 1 0 00 1 0",
                     rst_out, rst_out_n, grant, busy, done);
        end
        settle_cycles = 16'd4;
        release_reset();
        measure(1'b0);
        check_por("repor");
    endtask

`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
    task automatic test_wdog();
        int early;
        int fired_seen;
        early = 0;
        hold_cycles = 16'd3; settle_cycles = 16'd2;
        for (int k = 1; k <= WDOG - 1; k++) begin
            @(negedge clk);
            if (wdog_fired || busy) early++;
        end
        req = 2'b01;
        measure(1'b1);
        tests_run++;
        if (early !== 0 || m_first_fired !== 1'b1 || m_first_gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL wdog_fire: early=%0d fired=%b grant=%b required 0 1 00", early, m_first_fired, m_first_gnt);
        end
        tests_run++;
        if (m_hi !== POR || m_settle !== 2 || m_busy !== POR + 3) begin
            tests_failed++;
            $display("FAIL wdog_seq: hi=%0d settle=%0d busy=%0d required %0d 2 %0d", m_hi, m_settle, m_busy, POR, POR + 3);
        end
        measure(1'b0);
        tests_run++;
        if (m_first_gnt !== 2'b01 || m_hi !== 3) begin
            tests_failed++;
            $display("FAIL wdog_req_waits: grant=%b hi=%0d required 01 3", m_first_gnt, m_hi);
        end
        fired_seen = 0;
        for (int k = 0; k < 40; k++) begin
            wdog_kick = (k % 5 == 4);
            @(negedge clk);
            if (wdog_fired || busy) fired_seen++;
        end
        wdog_kick = 1'b0;
        tests_run++;
        if (fired_seen !== 0) begin
            tests_failed++;
            $display("FAIL wdog_kicked: fired_or_busy=%0d required 0", fired_seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_por();
        test_single();
        test_hold_zero();
        test_round_robin();
        test_reset_mid();
`ifdef UVMT_MEM_ST_RST_SEQ_WDOG_EN
        test_wdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
